full_adder_1b: RTL and testbench

One-bit full adder with a registered 2-bit result stage, used as the basic bit cell for ripple-carry arithmetic and as a bring-up block for the clocked datapath. The gate-level sum and carry are combinational. A registered copy of the 2-bit result, {Cout, S}, is captured every clock for synchronous consumers. An optional self-check compares the gate-level result with an arithmetic reference.

---
 rtl/full_adder_1b_pkg.sv | 15 +
 rtl/full_adder_1b_half_adder.sv | 12 +
 rtl/full_adder_1b.sv | 78 +++++++
 tb/tb_full_adder_1b.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_1b_pkg.sv
// Shared widths, result type and reset constant for the registered full adder.
package full_adder_1b_pkg;

    localparam int RES_W = 2;

    typedef logic [RES_W-1:0] res_t;

    localparam res_t RES_RST = '0;

    // Arithmetic reference: plain unsigned add of the three input bits.
    function automatic res_t ref_add(input logic a, input logic b, input logic c);
        return res_t'({1'b0, a} + {1'b0, b} + {1'b0, c});
    endfunction

endpackage

// File: rtl/full_adder_1b_half_adder.sv
// Gate-level half adder: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder_1b.sv
// One-bit full adder built from two half adders, with a registered {Cout,S} stage.
// Optional sticky self-check against an arithmetic reference: FULL_ADDER_1B_SELFCHECK_EN.
module full_adder_1b
    import full_adder_1b_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    output logic       S,
    output logic       Cout,
    output logic [1:0] num,
    output logic       valid,
    output logic       err
);

    logic p_w;
    logic g1_w;
    logic g2_w;
    logic s_w;
    logic cout_w;

    half_adder u_ha0 (.a(A),   .b(B),   .s(p_w), .c(g1_w));
    half_adder u_ha1 (.a(p_w), .b(Cin), .s(s_w), .c(g2_w));

    assign cout_w = g1_w | g2_w;
    assign S      = s_w;
    assign Cout   = cout_w;

    res_t num_d;
    res_t num_q;
    logic valid_d;
    logic valid_q;

    always_comb begin
        num_d   = {cout_w, s_w};
        valid_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num_q   <= RES_RST;
            valid_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign num   = num_q;
    assign valid = valid_q;

`ifdef FULL_ADDER_1B_SELFCHECK_EN
    res_t ref_w;
    logic err_d;
    logic err_q;

    // Once set, err holds until reset so a single bad edge is never lost.
    always_comb begin
        ref_w = ref_add(A, B, Cin);
        err_d = err_q | (ref_w != num_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_1b.sv
// Bench for full_adder_1b: vector table, reset corners, random run against an arithmetic model.
module tb_full_adder_1b;

    logic       clock;
    logic       reset;
    logic       A;
    logic       B;
    logic       Cin;
    logic       S;
    logic       Cout;
    logic [1:0] num;
    logic       valid;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    full_adder_1b dut (
        .clock(clock),
        .reset(reset),
        .A(A),
        .B(B),
        .Cin(Cin),
        .S(S),
        .Cout(Cout),
        .num(num),
        .valid(valid),
        .err(err)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp_cs;
        logic [1:0] exp_num;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c);
        A   = a;
        B   = b;
        Cin = c;
    endtask

    function automatic logic [1:0] model(input logic a, input logic b, input logic c);
        int sum;
        sum = int'(a) + int'(b) + int'(c);
        return sum[1:0];
    endfunction

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'd1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 2'd1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 2'd2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b01, 2'd1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 2'b10, 2'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2'b10, 2'd2};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b11, 2'd3};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        chk("rst_num", 32'(num), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        #1 chk("rst_comb", 32'({Cout, S}), 32'b01);
        @(posedge clock); #1;
        chk("rst_hold_num", 32'(num), 32'd0);
        chk("rst_hold_valid", 32'(valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // exhaustive table sweep
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive(tbl[i].a, tbl[i].b, tbl[i].cin);
            #1 chk($sformatf("sweep_comb_%0d", i), 32'({Cout, S}), 32'(tbl[i].exp_cs));
            @(posedge clock); #1;
            chk($sformatf("sweep_num_%0d", i), 32'(num), 32'(tbl[i].exp_num));
            chk($sformatf("sweep_valid_%0d", i), 32'(valid), 32'd1);
        end
        chk("sweep_err", 32'(err), 32'd0);

        // mid-run reset with A=1,B=0,Cin=1 held
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1);
        @(posedge clock); #1;
        chk("mid_pre_num", 32'(num), 32'b10);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_num", 32'(num), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_comb", 32'({Cout, S}), 32'b10);
        @(posedge clock); #1;
        chk("mid_rst_edge_num", 32'(num), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("mid_rel_num", 32'(num), 32'b10);
        chk("mid_rel_valid", 32'(valid), 32'd1);

        // random stimulus with scoreboard
        for (int n = 0; n < 200; n++) begin
            logic a, b, c;
            logic [1:0] e;
            @(negedge clock);
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            drive(a, b, c);
            #1 chk("rand_comb", 32'({Cout, S}), 32'(model(a, b, c)));
            exp_q.push_back(model(A, B, Cin));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            chk("rand_num", 32'(num), 32'(e));
        end
        chk("rand_err", 32'(err), 32'd0);

`ifdef FULL_ADDER_1B_SELFCHECK_EN
        // corrupt the gate-level sum for one edge; err must latch
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0);
        force dut.s_w = 1'b0;
        @(posedge clock); #1;
        chk("force_err", 32'(err), 32'd1);
        @(negedge clock);
        release dut.s_w;
        repeat (3) @(posedge clock);
        #1 chk("force_err_sticky", 32'(err), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("force_err_rst", 32'(err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("force_err_after", 32'(err), 32'd0);
`else
        repeat (3) @(posedge clock);
        #1 chk("noselfcheck_err", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
